// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port RAM (registered inputs, 1-cycle
// read) between requesters A and B, and zero-fills the RAM after reset or on
// clr_req. Each access runs IDLE -> GRANT -> WAIT, giving one access per
// three cycles. Every output is registered.
// Build option: define RAM_ARB_RR_EN for round-robin arbitration on ties.
// The default build uses fixed priority, where A always wins.
module ram_access_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_GRANT = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                win_b_q, win_b_d;     // winner of the access in flight
  logic                rd_q, rd_d;           // access in flight is a read
  logic                a_gnt_q, a_gnt_d;
  logic                b_gnt_q, b_gnt_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_wren_q, mem_wren_d;
  logic                sel_b;

`ifdef RAM_ARB_RR_EN
  logic                last_b_q, last_b_d;   // last requester granted

  // Round-robin select: on a tie, the requester not granted last wins
  always_comb begin
    if (a_req && b_req) sel_b = ~last_b_q;
    else                sel_b = b_req;
  end

  // Last-winner flag starts at B so A wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end
`else
  // Fixed priority select: A beats B whenever A requests
  always_comb begin
    sel_b = ~a_req;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    win_b_d    = win_b_q;
    rd_d       = rd_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wren_d = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_b_d   = last_b_q;
`endif

    case (state_q)
      S_CLEAR: begin
        mem_wren_d = 1'b1;
        mem_addr_d = clr_cnt_q;
        mem_data_d = '0;
        clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end else if (a_req || b_req) begin
          win_b_d    = sel_b;
          rd_d       = sel_b ? ~b_we : ~a_we;
          mem_addr_d = sel_b ? b_addr : a_addr;
          mem_data_d = sel_b ? b_wdata : a_wdata;
          mem_wren_d = sel_b ? b_we : a_we;
          a_gnt_d    = ~sel_b;
          b_gnt_d    = sel_b;
`ifdef RAM_ARB_RR_EN
          last_b_d   = sel_b;
`endif
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_q) begin
          rdata_d    = mem_q;
          a_rvalid_d = ~win_b_q;
          b_rvalid_d = win_b_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset restarts a full clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      win_b_q    <= 1'b0;
      rd_q       <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b1;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      win_b_q    <= win_b_d;
      rd_q       <= rd_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wren = mem_wren_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: drives ram_access_arbiter against a behavioural
// RAM plus a transaction-level reference model (memory image, arbitration
// winner, last read data). Inputs change on falling edges; outputs are
// sampled on falling edges.
module tb_ram_access_arbiter;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_req;
  logic       a_req, b_req, a_we, b_we;
  logic [4:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_wren;
  logic [3:0] rdata, mem_data, mem_q;
  logic [4:0] mem_addr;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] ref_mem [32];
  logic [3:0] exp_rdata;
  bit         model_last_b;

  // Behavioural RAM: registered address/data/wren, 1-cycle read
  logic [3:0] ram [32];
  logic [4:0] ram_addr_r;

  ram_access_arbiter #(.ADDR_W(5), .DATA_W(4), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_addr_r <= mem_addr;
    if (mem_wren === 1'b1) ram[mem_addr] <= mem_data;
  end
  assign mem_q = ram[ram_addr_r];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // At most one grant and one rvalid in any cycle
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
      check("rvalid_onehot", 32'(a_rvalid & b_rvalid), 32'd0);
    end
  end

  // Expect `lead` idle cycles then 32 zero-writes to addresses 0..31
  task automatic expect_clear(input int lead);
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      check("clr_lead_wren", 32'(mem_wren), 32'd0);
      clr_req = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("clr_wren", 32'(mem_wren), 32'd1);
      check("clr_addr", 32'(mem_addr), 32'(i));
      check("clr_data", 32'(mem_data), 32'd0);
      check("clr_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
  endtask

  // Assert reset (caller is at a falling edge), check async reset values,
  // release and expect the full clear afterwards
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      check("rst_hold_wren", 32'(mem_wren), 32'd0);
    end
    reset = 1'b0;
    model_last_b = 1'b1;
    exp_rdata = 4'h0;
    expect_clear(0);
    @(negedge clk);
    check("post_clr_busy", 32'(busy), 32'd0);
    check("post_clr_wren", 32'(mem_wren), 32'd0);
  endtask

  // Serve one access from the currently driven requests and check it end to end
  task automatic service_one(output bit won_b);
    bit exp_b, we;
    logic [4:0] ad;
    logic [3:0] wd;
    int n;
    if (a_req && b_req) exp_b = RR ? !model_last_b : 1'b0;
    else                exp_b = b_req;
    we = exp_b ? b_we : a_we;
    ad = exp_b ? b_addr : a_addr;
    wd = exp_b ? b_wdata : a_wdata;
    n = 0;
    @(negedge clk);
    while (!(a_gnt || b_gnt) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("gnt_latency", 32'(n), 32'd0);
    check("a_gnt", 32'(a_gnt), 32'(!exp_b));
    check("b_gnt", 32'(b_gnt), 32'(exp_b));
    check("gnt_busy", 32'(busy), 32'd1);
    check("gnt_mem_wren", 32'(mem_wren), 32'(we));
    check("gnt_mem_addr", 32'(mem_addr), 32'(ad));
    if (we) check("gnt_mem_data", 32'(mem_data), 32'(wd));
    model_last_b = exp_b;
    won_b = exp_b;
    @(negedge clk);
    check("wait_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    check("wait_mem_wren", 32'(mem_wren), 32'd0);
    @(negedge clk);
    if (!we) exp_rdata = ref_mem[ad];
    else     ref_mem[ad] = wd;
    check("a_rvalid", 32'(a_rvalid), 32'(!exp_b && !we));
    check("b_rvalid", 32'(b_rvalid), 32'(exp_b && !we));
    check("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  task automatic drive_a(input logic we, input logic [4:0] ad, input logic [3:0] wd);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic drive_b(input logic we, input logic [4:0] ad, input logic [3:0] wd);
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  initial begin
    bit wb;
    int nb, n;
    reset = 1'b0; clr_req = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    for (int i = 0; i < 32; i++) begin ram[i] = 4'h0; ref_mem[i] = 4'h0; end
    exp_rdata = 4'h0;
    model_last_b = 1'b1;

    @(negedge clk);
    apply_reset();

    // A writes 5 = F, B reads it back
    drive_a(1'b1, 5'd5, 4'hF); service_one(wb); a_req = 1'b0;
    drive_b(1'b0, 5'd5, 4'h0); service_one(wb); b_req = 1'b0;

    // Address wrap: 31 and 0 hold distinct values
    drive_a(1'b1, 5'd31, 4'h1); service_one(wb); a_req = 1'b0;
    drive_b(1'b1, 5'd0, 4'h2);  service_one(wb); b_req = 1'b0;
    drive_b(1'b0, 5'd31, 4'h0); service_one(wb); b_req = 1'b0;
    drive_a(1'b0, 5'd0, 4'h0);  service_one(wb); a_req = 1'b0;

    // clr_req beats a simultaneous a_req; the read then returns 0
    clr_req = 1'b1;
    drive_a(1'b0, 5'd5, 4'h0);
    expect_clear(1);
    service_one(wb); a_req = 1'b0;

    // Reset during WAIT of a B read drops the access
    drive_b(1'b0, 5'd5, 4'h0);
    n = 0;
    @(negedge clk);
    while (!b_gnt && n < 20) begin n++; @(negedge clk); end
    check("mid_b_gnt", 32'(b_gnt), 32'd1);
    b_req = 1'b0;
    @(negedge clk);
    apply_reset();

    // Both requesters hold reads for 4 services
    @(negedge clk);
    apply_reset();
    drive_a(1'b0, 5'd3, 4'h0);
    drive_b(1'b0, 5'd7, 4'h0);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      service_one(wb);
      check("hold_order", 32'(wb), RR ? 32'(i % 2) : 32'd0);
      nb += int'(wb);
    end
    a_req = 1'b0; b_req = 1'b0;
    check("hold_b_gnts", 32'(nb), RR ? 32'd2 : 32'd0);

    // Randomized mix of single, contending and clear requests
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 11) == 0) begin
        clr_req = 1'b1;
        expect_clear(1);
        @(negedge clk);
        check("rnd_clr_busy", 32'(busy), 32'd0);
      end else begin
        int k;
        k = int'($urandom_range(1, 3));
        if (k[0]) drive_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
        if (k[1]) drive_b(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
        service_one(wb);
        if (wb) b_req = 1'b0; else a_req = 1'b0;
        if (a_req || b_req) begin
          service_one(wb);
          a_req = 1'b0; b_req = 1'b0;
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
